multi_port_free_list: RTL and testbench

//  Parametrised multi-port circular free list for rename resources, e.g. physical register numbers.

---
 rtl/multi_port_free_list.sv | 171 +++++++++++++++++
 tb/tb_multi_port_free_list.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multi_port_free_list.sv
// Multi-port circular free list with a self-initialising fill FSM.
// Define RSD_FREE_LIST_CHECKPOINT_EN to add head checkpoint save/restore.
module multi_port_free_list #(
    parameter int ENTRY_NUM       = 64,
    parameter int ENTRY_BIT_WIDTH = 6,
    parameter int POP_WIDTH       = 2,
    parameter int PUSH_WIDTH      = 2,
    parameter int INIT_NUM        = 32,
    parameter int INIT_VALUE_BASE = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
`ifdef RSD_FREE_LIST_CHECKPOINT_EN
    input  logic                                 ckptSave,
    input  logic                                 ckptRestore,
`endif
    output logic                                 ready,
    output logic                                 canPop,
    input  logic [POP_WIDTH-1:0]                 popReq,
    output logic [POP_WIDTH*ENTRY_BIT_WIDTH-1:0] popData,
    input  logic [PUSH_WIDTH-1:0]                pushReq,
    input  logic [PUSH_WIDTH*ENTRY_BIT_WIDTH-1:0] pushData,
    output logic [$clog2(ENTRY_NUM):0]           count,
    output logic                                 overflow,
    output logic                                 underflow
);
    localparam int IDX_W  = $clog2(ENTRY_NUM);
    localparam int PTR_W  = IDX_W + 1;
    localparam int SUM_W  = PTR_W + 1;
    localparam int INIT_W = $clog2(INIT_NUM + 1);

    typedef enum logic {S_INIT, S_READY} state_t;
    state_t r_state, w_stateNext;

    logic [ENTRY_BIT_WIDTH-1:0] r_mem [ENTRY_NUM];
    logic [PTR_W-1:0]  r_head, r_tail, w_headNext, w_tailNext;
    logic [INIT_W-1:0] r_initCnt, w_initCntNext;
    logic              r_ready, r_overflow, r_underflow, w_ovfNext, w_unfNext;
    logic [SUM_W-1:0]  w_nPop, w_nPush, w_count, w_cntAfterPop, w_pushOff;
    logic              w_popOk, w_pushOk;
    int                w_initRem, w_nInit;
    logic [PUSH_WIDTH-1:0]      w_wrEn;
    logic [IDX_W-1:0]           w_wrIdx  [PUSH_WIDTH];
    logic [ENTRY_BIT_WIDTH-1:0] w_wrData [PUSH_WIDTH];
    logic [IDX_W-1:0]           w_rdIdx  [POP_WIDTH];
`ifdef RSD_FREE_LIST_CHECKPOINT_EN
    logic [PTR_W-1:0]  r_ckptHead, w_ckptNext;
`endif

    assign w_count   = SUM_W'(PTR_W'(r_tail - r_head));
    assign count     = PTR_W'(w_count);
    assign canPop    = (w_count >= SUM_W'(POP_WIDTH));
    assign ready     = r_ready;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // A requesting lane reads the slot matching its rank among set lanes,
    // so sparse masks still consume entries in order from head.
    always_comb begin
        w_nPop  = '0;
        popData = '0;
        for (int k = 0; k < POP_WIDTH; k++) begin
            w_rdIdx[k] = popReq[k] ? IDX_W'(r_head + PTR_W'(w_nPop))
                                   : IDX_W'(r_head + PTR_W'(k));
            popData[k*ENTRY_BIT_WIDTH +: ENTRY_BIT_WIDTH] = r_mem[w_rdIdx[k]];
            if (popReq[k]) w_nPop = w_nPop + SUM_W'(1);
        end
        w_nPush = '0;
        for (int k = 0; k < PUSH_WIDTH; k++)
            if (pushReq[k]) w_nPush = w_nPush + SUM_W'(1);
    end

    always_comb begin
        w_stateNext   = r_state;
        w_headNext    = r_head;
        w_tailNext    = r_tail;
        w_initCntNext = r_initCnt;
        w_ovfNext     = r_overflow;
        w_unfNext     = r_underflow;
        w_popOk       = 1'b0;
        w_pushOk      = 1'b0;
        w_cntAfterPop = '0;
        w_pushOff     = '0;
        w_initRem     = INIT_NUM - int'(r_initCnt);
        w_nInit       = 0;
        w_wrEn        = '0;
`ifdef RSD_FREE_LIST_CHECKPOINT_EN
        w_ckptNext    = r_ckptHead;
`endif
        for (int k = 0; k < PUSH_WIDTH; k++) begin
            w_wrIdx[k]  = '0;
            w_wrData[k] = '0;
        end
        unique case (r_state)
            S_INIT: begin
                for (int k = 0; k < PUSH_WIDTH; k++) begin
                    if (k < w_initRem) begin
                        w_wrEn[k]   = 1'b1;
                        w_wrIdx[k]  = IDX_W'(r_tail + PTR_W'(k));
                        w_wrData[k] = ENTRY_BIT_WIDTH'(INIT_VALUE_BASE
                                      + int'(r_initCnt) + k);
                        w_nInit     = w_nInit + 1;
                    end
                end
                w_tailNext    = r_tail + PTR_W'(w_nInit);
                w_initCntNext = r_initCnt + INIT_W'(w_nInit);
                if (w_initRem <= PUSH_WIDTH) w_stateNext = S_READY;
            end
            S_READY: begin
                w_popOk    = (w_nPop <= w_count);
                w_headNext = w_popOk ? r_head + PTR_W'(w_nPop) : r_head;
                w_unfNext  = r_underflow | ~w_popOk;
`ifdef RSD_FREE_LIST_CHECKPOINT_EN
                if (ckptRestore) begin
                    w_headNext = r_ckptHead;
                    w_unfNext  = r_underflow;
                end else if (ckptSave) begin
                    w_ckptNext = w_headNext;
                end
`endif
                w_cntAfterPop = SUM_W'(PTR_W'(r_tail - w_headNext));
                w_pushOk = (w_cntAfterPop + w_nPush) <= SUM_W'(ENTRY_NUM);
                if (w_pushOk) begin
                    for (int k = 0; k < PUSH_WIDTH; k++) begin
                        if (pushReq[k]) begin
                            w_wrEn[k]   = 1'b1;
                            w_wrIdx[k]  = IDX_W'(r_tail + PTR_W'(w_pushOff));
                            w_wrData[k] = pushData[k*ENTRY_BIT_WIDTH +: ENTRY_BIT_WIDTH];
                            w_pushOff   = w_pushOff + SUM_W'(1);
                        end
                    end
                    w_tailNext = r_tail + PTR_W'(w_nPush);
                end else begin
                    w_ovfNext = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_head      <= '0;
            r_tail      <= '0;
            r_initCnt   <= '0;
            r_ready     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
`ifdef RSD_FREE_LIST_CHECKPOINT_EN
            r_ckptHead  <= '0;
`endif
        end else begin
            r_state     <= w_stateNext;
            r_head      <= w_headNext;
            r_tail      <= w_tailNext;
            r_initCnt   <= w_initCntNext;
            r_ready     <= (w_stateNext == S_READY);
            r_overflow  <= w_ovfNext;
            r_underflow <= w_unfNext;
`ifdef RSD_FREE_LIST_CHECKPOINT_EN
            r_ckptHead  <= w_ckptNext;
`endif
        end
    end

    // Storage has no reset; the init FSM fills it after every reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PUSH_WIDTH; k++)
            if (w_wrEn[k]) r_mem[w_wrIdx[k]] <= w_wrData[k];
    end
endmodule

// File: tb/tb_multi_port_free_list.sv
// Directed bench for multi_port_free_list: init, pops, pushes,
// overflow/underflow, wrap-around drain and mid-run reset.
module tb_multi_port_free_list;
    logic        clk = 1'b0;
    logic        rst;
    logic        ready, canPop, overflow, underflow;
    logic [1:0]  popReq, pushReq;
    logic [11:0] popData, pushData;
    logic [6:0]  count;
`ifdef RSD_FREE_LIST_CHECKPOINT_EN
    logic        ckptSave, ckptRestore;
`endif

    int total = 0;
    int bad   = 0;
    int q[$];

    multi_port_free_list dut (
        .clk       (clk),
        .rst       (rst),
`ifdef RSD_FREE_LIST_CHECKPOINT_EN
        .ckptSave   (ckptSave),
        .ckptRestore(ckptRestore),
`endif
        .ready     (ready),
        .canPop    (canPop),
        .popReq    (popReq),
        .popData   (popData),
        .pushReq   (pushReq),
        .pushData  (pushData),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] lane(input int k);
        return popData[k*6 +: 6];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        chk(tag, n, 16);
    endtask

    task automatic push(input logic [1:0] m, input logic [5:0] a,
                        input logic [5:0] b);
        pushReq  = m;
        pushData = {b, a};
        tick();
        pushReq  = 2'b00;
    endtask

    initial begin
        rst = 1'b1; popReq = '0; pushReq = '0; pushData = '0;
`ifdef RSD_FREE_LIST_CHECKPOINT_EN
        ckptSave = 1'b0; ckptRestore = 1'b0;
`endif
        tick();
        chk("rst_ready", ready, 0);
        chk("rst_count", count, 0);
        rst = 1'b0;
        wait_ready("init_cycles");
        chk("init_count", count, 32);
        chk("init_lane0", lane(0), 32);
        chk("init_lane1", lane(1), 33);
        chk("init_canpop", canPop, 1);
        chk("init_flags", {overflow, underflow}, 0);

        popReq = 2'b11; tick(); popReq = 2'b00;
        chk("pop2_count", count, 30);
        chk("pop2_lane0", lane(0), 34);
        chk("pop2_lane1", lane(1), 35);

        popReq = 2'b10; #1;
        chk("sparse_lane1", lane(1), 34);
        tick(); popReq = 2'b00;
        chk("sparse_count", count, 29);
        chk("sparse_lane0", lane(0), 35);

        popReq = 2'b11; pushReq = 2'b11; pushData = {6'd7, 6'd5};
        tick(); popReq = 2'b00; pushReq = 2'b00;
        chk("simul_count", count, 29);
        chk("simul_lane0", lane(0), 37);
        for (int v = 37; v < 64; v++) q.push_back(v);
        q.push_back(5);
        q.push_back(7);

        for (int i = 0; i < 17; i++) begin
            push(2'b11, 6'(2*i), 6'(2*i+1));
            q.push_back(2*i);
            q.push_back(2*i+1);
        end
        push(2'b10, 6'd0, 6'd50);
        q.push_back(50);
        chk("full_count", count, 64);
        chk("full_ovf0", overflow, 0);
        push(2'b01, 6'd60, 6'd0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 64);

        for (int i = 0; i < 32; i++) begin
            popReq = 2'b11; #1;
            chk($sformatf("drain%0d_l0", i), lane(0), q[0]);
            chk($sformatf("drain%0d_l1", i), lane(1), q[1]);
            tick();
            void'(q.pop_front());
            void'(q.pop_front());
        end
        popReq = 2'b00;
        chk("drain_count", count, 0);
        chk("drain_canpop", canPop, 0);
        chk("ovf_sticky", overflow, 1);

        push(2'b01, 6'd9, 6'd0);
        chk("one_count", count, 1);
        popReq = 2'b11; tick(); popReq = 2'b00;
        chk("unf_flag", underflow, 1);
        chk("unf_count", count, 1);
        chk("unf_lane0", lane(0), 9);

        rst = 1'b1; tick();
        chk("rst2_flags", {overflow, underflow}, 0);
        chk("rst2_ready", ready, 0);
        chk("rst2_count", count, 0);
        rst = 1'b0;
        wait_ready("reinit_cycles");
        chk("reinit_count", count, 32);
        chk("reinit_lane0", lane(0), 32);
        chk("reinit_lane1", lane(1), 33);

`ifdef RSD_FREE_LIST_CHECKPOINT_EN
        popReq = 2'b11; tick(); tick(); popReq = 2'b00;
        ckptSave = 1'b1; tick(); ckptSave = 1'b0;
        popReq = 2'b11; tick(); tick(); tick(); popReq = 2'b00;
        chk("ckpt_popped", count, 22);
        ckptRestore = 1'b1; tick(); ckptRestore = 1'b0;
        chk("ckpt_count", count, 28);
        chk("ckpt_lane0", lane(0), 36);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
